// File: rtl/vga_term_ctrl.sv
// Terminal controller: ASCII stream to VRAM writes, cursor tracking, row-copy scroll and clear.
// Optional feature macro: VGA_TERM_BACKSPACE_EN (0x08 moves the cursor left and blanks that cell).
module vga_term_ctrl #(
    parameter int         H_CHARS    = 40,
    parameter int         V_CHARS    = 24,
    parameter logic [5:0] BLANK_CODE = 6'h20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clr_screen,
    input  logic       disp_req,
    input  logic [9:0] disp_addr,
    output logic [9:0] vram_read_addr,
    output logic       vram_r_en,
    input  logic [5:0] vram_dout,
    output logic [9:0] vram_write_addr,
    output logic       vram_w_en,
    output logic [5:0] vram_din,
    output logic [5:0] cursor_h,
    output logic [4:0] cursor_v
);

    localparam logic [9:0] LAST_CELL  = 10'(H_CHARS * V_CHARS - 1);
    localparam logic [9:0] ROW_STRIDE = 10'(H_CHARS);
    localparam logic [9:0] LAST_ROW0  = 10'(H_CHARS * (V_CHARS - 1));
    localparam logic [5:0] LAST_COL   = 6'(H_CHARS - 1);
    localparam logic [4:0] LAST_ROW   = 5'(V_CHARS - 1);

    typedef enum logic [2:0] {
        S_CLEAR        = 3'd0,
        S_IDLE         = 3'd1,
        S_WRITE        = 3'd2,
        S_SCROLL_COPY  = 3'd3,
        S_SCROLL_BLANK = 3'd4
    } state_t;

    state_t     r_state;
    logic [9:0] r_cnt;
    logic [9:0] r_src;
    logic [9:0] r_rd_src;
    logic       r_rd_pend;
    logic       r_rd_done;
    logic       r_scroll;
    logic       r_char_ready;
    logic       r_w_en;
    logic [9:0] r_waddr;
    logic [5:0] r_din;
    logic [5:0] r_cursor_h;
    logic [4:0] r_cursor_v;

    logic       w_ctrl_rd;
    logic [9:0] w_row_base;
    logic [9:0] w_cell_addr;
    logic [5:0] w_code;
    logic       w_printable;
    logic       w_is_cr;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_newline;
    logic       w_bs_act;

    // Scanout owns the read port whenever it asks; the copy engine only reads in free cycles.
    assign w_ctrl_rd      = (r_state == S_SCROLL_COPY) && !r_rd_done && !disp_req;
    assign vram_read_addr = disp_req ? disp_addr : r_src;
    assign vram_r_en      = disp_req | w_ctrl_rd;

    assign w_row_base  = 10'(r_cursor_v) * ROW_STRIDE;
    assign w_cell_addr = w_row_base + {4'b0000, r_cursor_h};
    assign w_code      = char_in[6] ? {1'b0, char_in[4:0]} : char_in[5:0];
    assign w_printable = char_in[6] | char_in[5];
    assign w_is_cr     = (char_in == 7'h0D);
    assign w_h_last    = (r_cursor_h == LAST_COL);
    assign w_v_last    = (r_cursor_v == LAST_ROW);
    assign w_newline   = w_is_cr | (w_printable & w_h_last);
`ifdef VGA_TERM_BACKSPACE_EN
    assign w_bs_act    = (char_in == 7'h08) && (r_cursor_h != 6'd0);
`else
    assign w_bs_act    = 1'b0;
`endif

    assign char_ready      = r_char_ready;
    assign vram_write_addr = r_waddr;
    assign vram_w_en       = r_w_en;
    assign vram_din        = r_din;
    assign cursor_h        = r_cursor_h;
    assign cursor_v        = r_cursor_v;

    // Controller FSM with registered VRAM write port, cursor and handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEAR;
            r_cnt        <= 10'd0;
            r_src        <= 10'd0;
            r_rd_src     <= 10'd0;
            r_rd_pend    <= 1'b0;
            r_rd_done    <= 1'b0;
            r_scroll     <= 1'b0;
            r_char_ready <= 1'b0;
            r_w_en       <= 1'b0;
            r_waddr      <= 10'd0;
            r_din        <= 6'd0;
            r_cursor_h   <= 6'd0;
            r_cursor_v   <= 5'd0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_w_en  <= 1'b1;
                    r_waddr <= r_cnt;
                    r_din   <= BLANK_CODE;
                    if (r_cnt == LAST_CELL) begin
                        r_state      <= S_IDLE;
                        r_char_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_IDLE: begin
                    if (clr_screen) begin
                        r_state      <= S_CLEAR;
                        r_cnt        <= 10'd0;
                        r_char_ready <= 1'b0;
                        r_w_en       <= 1'b0;
                        r_cursor_h   <= 6'd0;
                        r_cursor_v   <= 5'd0;
                    end else if (char_valid && r_char_ready) begin
                        // The whole character is resolved at the handshake so w_en follows one cycle later.
                        r_state      <= S_WRITE;
                        r_char_ready <= 1'b0;
                        r_w_en       <= w_printable | w_bs_act;
                        r_waddr      <= w_bs_act ? (w_cell_addr - 10'd1) : w_cell_addr;
                        r_din        <= w_bs_act ? BLANK_CODE : w_code;
                        r_scroll     <= w_newline & w_v_last;
                        if (w_newline) begin
                            r_cursor_h <= 6'd0;
                        end else if (w_printable) begin
                            r_cursor_h <= r_cursor_h + 6'd1;
                        end else if (w_bs_act) begin
                            r_cursor_h <= r_cursor_h - 6'd1;
                        end else begin
                            r_cursor_h <= r_cursor_h;
                        end
                        if (w_newline && !w_v_last) begin
                            r_cursor_v <= r_cursor_v + 5'd1;
                        end else begin
                            r_cursor_v <= r_cursor_v;
                        end
                    end else begin
                        r_w_en <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_w_en <= 1'b0;
                    if (r_scroll) begin
                        r_state   <= S_SCROLL_COPY;
                        r_src     <= ROW_STRIDE;
                        r_rd_pend <= 1'b0;
                        r_rd_done <= 1'b0;
                    end else begin
                        r_state      <= S_IDLE;
                        r_char_ready <= 1'b1;
                    end
                end
                S_SCROLL_COPY: begin
                    // Data read last cycle lands one row up; a new read may issue in the same cycle.
                    if (r_rd_pend) begin
                        r_w_en  <= 1'b1;
                        r_waddr <= r_rd_src - ROW_STRIDE;
                        r_din   <= vram_dout;
                    end else begin
                        r_w_en <= 1'b0;
                    end
                    if (w_ctrl_rd) begin
                        r_rd_pend <= 1'b1;
                        r_rd_src  <= r_src;
                        if (r_src == LAST_CELL) begin
                            r_rd_done <= 1'b1;
                        end else begin
                            r_src <= r_src + 10'd1;
                        end
                    end else begin
                        r_rd_pend <= 1'b0;
                    end
                    if (r_rd_done && !r_rd_pend) begin
                        r_state <= S_SCROLL_BLANK;
                        r_cnt   <= LAST_ROW0;
                    end else begin
                        r_state <= S_SCROLL_COPY;
                    end
                end
                S_SCROLL_BLANK: begin
                    r_w_en  <= 1'b1;
                    r_waddr <= r_cnt;
                    r_din   <= BLANK_CODE;
                    if (r_cnt == LAST_CELL) begin
                        r_state      <= S_IDLE;
                        r_char_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                default: begin
                    r_state      <= S_CLEAR;
                    r_cnt        <= 10'd0;
                    r_char_ready <= 1'b0;
                    r_w_en       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl with a behavioural 1024x6 VRAM (sync read, sync write).
module tb_vga_term_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       clr_screen;
    logic       disp_req;
    logic [9:0] disp_addr;
    logic [9:0] vram_read_addr;
    logic       vram_r_en;
    logic [5:0] vram_dout;
    logic [9:0] vram_write_addr;
    logic       vram_w_en;
    logic [5:0] vram_din;
    logic [5:0] cursor_h;
    logic [4:0] cursor_v;

    logic [5:0] mem [0:1023];
    logic [5:0] rdata;
    logic       mem_init;
    logic       scan_en;
    int         wr_cnt;
    int         n_checks;
    int         n_fail;

    vga_term_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .char_in        (char_in),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .clr_screen     (clr_screen),
        .disp_req       (disp_req),
        .disp_addr      (disp_addr),
        .vram_read_addr (vram_read_addr),
        .vram_r_en      (vram_r_en),
        .vram_dout      (vram_dout),
        .vram_write_addr(vram_write_addr),
        .vram_w_en      (vram_w_en),
        .vram_din       (vram_din),
        .cursor_h       (cursor_h),
        .cursor_v       (cursor_v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model and write-pulse counter.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 6'h3F;
        end else if (vram_w_en) begin
            mem[vram_write_addr] <= vram_din;
        end
        if (vram_r_en) rdata <= mem[vram_read_addr];
        if (vram_w_en) wr_cnt <= wr_cnt + 1;
    end
    assign vram_dout = rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int budget, input string tag);
        for (int i = 0; i < budget && !char_ready; i++) @(negedge clk);
        check(tag, {31'd0, char_ready}, 32'd1);
    endtask

    // Returns at the negedge following the handshake edge, where the write is visible.
    task automatic send_char(input logic [6:0] c);
        wait_ready(50, "rdy_before_char");
        char_valid = 1'b1;
        char_in    = c;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    // Scanout stimulus: 50% disp_req with random addresses; read port must follow it.
    initial begin
        disp_req  = 1'b0;
        disp_addr = 10'd0;
        forever begin
            @(negedge clk);
            if (scan_en) begin
                disp_req  = ~disp_req;
                disp_addr = 10'($urandom_range(0, 1023));
            end else begin
                disp_req = 1'b0;
            end
            #1;
            if (disp_req) check("scan_addr", 32'(vram_read_addr), 32'(disp_addr));
        end
    end

    initial begin
        int bad;
        int base;
        logic [5:0] exp_code;
        n_checks   = 0;
        n_fail     = 0;
        wr_cnt     = 0;
        scan_en    = 1'b0;
        mem_init   = 1'b1;
        rst_n      = 1'b0;
        char_in    = 7'd0;
        char_valid = 1'b0;
        clr_screen = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, char_ready}, 32'd0);
        check("rst_wen", {31'd0, vram_w_en}, 32'd0);
        check("rst_waddr", 32'(vram_write_addr), 32'd0);
        check("rst_din", 32'(vram_din), 32'd0);
        check("rst_cur", {21'd0, cursor_v, cursor_h}, 32'd0);
        mem_init = 1'b0;
        @(negedge clk);
        base  = wr_cnt;
        rst_n = 1'b1;

        // Power-up clear.
        wait_ready(2000, "clear_done");
        @(negedge clk);
        check("clear_pulses", 32'(wr_cnt - base), 32'd960);
        bad = 0;
        for (int i = 0; i < 960; i++) if (mem[i] !== 6'h20) bad++;
        check("clear_cells", 32'(bad), 32'd0);
        check("clear_untouched960", 32'(mem[960]), 32'h3F);
        check("clear_untouched1023", 32'(mem[1023]), 32'h3F);
        check("clear_cur", {21'd0, cursor_v, cursor_h}, 32'd0);

        // Printable characters and case folding.
        send_char(7'h41);
        check("A_wen", {31'd0, vram_w_en}, 32'd1);
        check("A_addr", 32'(vram_write_addr), 32'd0);
        check("A_din", 32'(vram_din), 32'h01);
        check("A_cur_h", 32'(cursor_h), 32'd1);
        check("A_cur_v", 32'(cursor_v), 32'd0);
        check("A_ready_low", {31'd0, char_ready}, 32'd0);
        send_char(7'h42);
        send_char(7'h43);
        check("C_cur_h", 32'(cursor_h), 32'd3);

        send_char(7'h08);
`ifdef VGA_TERM_BACKSPACE_EN
        check("bs_wen", {31'd0, vram_w_en}, 32'd1);
        check("bs_addr", 32'(vram_write_addr), 32'd2);
        check("bs_din", 32'(vram_din), 32'h20);
        check("bs_cur_h", 32'(cursor_h), 32'd2);
`else
        check("bs_wen", {31'd0, vram_w_en}, 32'd0);
        check("bs_cur_h", 32'(cursor_h), 32'd3);
`endif
        check("bs_cur_v", 32'(cursor_v), 32'd0);

        send_char(7'h0D);
        check("cr_wen", {31'd0, vram_w_en}, 32'd0);
        check("cr_cur", {21'd0, cursor_v, cursor_h}, {21'd0, 5'd1, 6'd0});
        send_char(7'h07);
        check("ctl_wen", {31'd0, vram_w_en}, 32'd0);
        check("ctl_cur", {21'd0, cursor_v, cursor_h}, {21'd0, 5'd1, 6'd0});
        send_char(7'h0D);
        for (int i = 0; i < 5; i++) send_char(7'h30);
        check("pos_5_2", {21'd0, cursor_v, cursor_h}, {21'd0, 5'd2, 6'd5});
        send_char(7'h61);
        check("a_wen", {31'd0, vram_w_en}, 32'd1);
        check("a_addr", 32'(vram_write_addr), 32'd85);
        check("a_din", 32'(vram_din), 32'h01);
        send_char(7'h0D);
        send_char(7'h42);
        check("B_addr", 32'(vram_write_addr), 32'd120);
        check("B_din", 32'(vram_din), 32'h02);
        send_char(7'h7F);
        check("del_din", 32'(vram_din), 32'h1F);

        // clr_screen beats char_valid in IDLE.
        wait_ready(50, "rdy_before_clr");
        clr_screen = 1'b1;
        char_valid = 1'b1;
        char_in    = 7'h51;
        @(negedge clk);
        clr_screen = 1'b0;
        char_valid = 1'b0;
        check("clr_wen", {31'd0, vram_w_en}, 32'd0);
        check("clr_ready", {31'd0, char_ready}, 32'd0);
        check("clr_cur", {21'd0, cursor_v, cursor_h}, 32'd0);
        wait_ready(2000, "clr_done");
        @(negedge clk);
        check("clr_cell120", 32'(mem[120]), 32'h20);
        check("clr_cell0", 32'(mem[0]), 32'h20);

        // Fill rows with code r, finish with 'Z' at (39,23) to trigger a scroll.
        for (int r = 0; r < 23; r++)
            for (int c = 0; c < 40; c++) send_char(7'(7'h40 + r));
        check("fill_cur", {21'd0, cursor_v, cursor_h}, {21'd0, 5'd23, 6'd0});
        for (int c = 0; c < 39; c++) send_char(7'h57);
        scan_en = 1'b1;
        send_char(7'h5A);
        check("Z_wen", {31'd0, vram_w_en}, 32'd1);
        check("Z_addr", 32'(vram_write_addr), 32'd959);
        check("Z_din", 32'(vram_din), 32'h1A);
        wait_ready(6000, "scroll_done");
        @(negedge clk);
        scan_en = 1'b0;
        check("scroll_cur", {21'd0, cursor_v, cursor_h}, {21'd0, 5'd23, 6'd0});
        check("scroll_0", 32'(mem[0]), 32'd1);
        check("scroll_39", 32'(mem[39]), 32'd1);
        check("scroll_880", 32'(mem[880]), 32'd23);
        check("scroll_919", 32'(mem[919]), 32'h1A);
        check("scroll_920", 32'(mem[920]), 32'h20);
        check("scroll_959", 32'(mem[959]), 32'h20);
        check("scroll_960", 32'(mem[960]), 32'h3F);
        bad = 0;
        for (int i = 0; i < 960; i++) begin
            if (i < 880)      exp_code = 6'(i / 40 + 1);
            else if (i < 919) exp_code = 6'd23;
            else if (i < 920) exp_code = 6'h1A;
            else              exp_code = 6'h20;
            if (mem[i] !== exp_code) bad++;
        end
        check("scroll_cells", 32'(bad), 32'd0);

        // Reset in the middle of a scroll restarts the clear.
        for (int c = 0; c < 39; c++) send_char(7'h30);
        send_char(7'h5A);
        for (int i = 0; i < 3000 && !(vram_r_en && vram_read_addr == 10'd500); i++) @(negedge clk);
        check("midscroll_src", 32'(vram_read_addr), 32'd500);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wen", {31'd0, vram_w_en}, 32'd0);
        check("mid_rst_waddr", 32'(vram_write_addr), 32'd0);
        check("mid_rst_din", 32'(vram_din), 32'd0);
        check("mid_rst_ready", {31'd0, char_ready}, 32'd0);
        check("mid_rst_cur", {21'd0, cursor_v, cursor_h}, 32'd0);
        @(negedge clk);
        base  = wr_cnt;
        rst_n = 1'b1;
        wait_ready(2000, "reclear_done");
        @(negedge clk);
        check("reclear_pulses", 32'(wr_cnt - base), 32'd960);
        check("reclear_500", 32'(mem[500]), 32'h20);
        check("reclear_0", 32'(mem[0]), 32'h20);
        check("reclear_cur", {21'd0, cursor_v, cursor_h}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
